// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared select encoding and sign-extension helper for the program sequencer
package pc_seq_pkg;

    typedef enum logic [2:0] {
        HOLD    = 3'b000,
        INC     = 3'b001,
        BRANCH  = 3'b010,
        JREL    = 3'b011,
        JABS    = 3'b100,
        CALL    = 3'b101,
        RET     = 3'b110,
        ILLEGAL = 3'b111
    } ps_e;

    localparam int SEXT_W = 32;

    // Replicates bit w-1 of v into every higher bit; callers truncate to their own width.
    function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v, input int w);
        logic [SEXT_W-1:0] r;
        r = v;
        for (int i = 0; i < SEXT_W; i++) begin
            if (i >= w) begin
                r[i] = v[w-1];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// rtl/pc_return_stack.sv - DEPTH x PC_W return-address LIFO with guarded push/pop
module pc_return_stack #(
    parameter int PC_W  = 6,
    parameter int DEPTH = 4,
    parameter int SP_W  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] top,
    output logic [SP_W-1:0] sp,
    output logic            full,
    output logic            empty
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [PC_W-1:0]  mem [DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (sp == SP_W'(DEPTH));
    assign empty   = (sp == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !push;
    assign wr_idx  = IDX_W'(sp);
    assign rd_idx  = IDX_W'(sp - SP_W'(1));
    assign top     = mem[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
        end else if (do_push) begin
            sp <= sp + SP_W'(1);
        end else if (do_pop) begin
            sp <= sp - SP_W'(1);
        end
    end

    // Contents are deliberately left unreset; sp alone marks which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with branch, jumps, call/return stack, stall and sticky faults
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W     = 6,
    parameter int A_W      = 4,
    parameter int OFF_W    = 4,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0,
    parameter int SP_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk_main,
    input  logic             reset,
    input  logic             stall,
    input  logic [2:0]       PS,
    input  logic [A_W-1:0]   A,
    input  logic [OFF_W-1:0] offset,
    output logic [PC_W-1:0]  PC,
    output logic [SP_W-1:0]  sp,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             err_ovf,
    output logic             err_unf,
    output logic             err_ill
);

    logic [PC_W-1:0] inc;
    logic [PC_W-1:0] off_sx;
    logic [PC_W-1:0] rel_target;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] top;
    logic            push;
    logic            pop;
    logic            set_ovf;
    logic            set_unf;
    logic            set_ill;

    assign inc        = PC + PC_W'(1);
    assign off_sx     = PC_W'(sext(SEXT_W'(offset), OFF_W));
    assign rel_target = PC + off_sx + PC_W'(1);

    // Stall masks every side effect here, so no fault can be flagged while frozen.
    always_comb begin
        pc_next = PC;
        push    = 1'b0;
        pop     = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        set_ill = 1'b0;
        if (!stall) begin
            case (ps_e'(PS))
                HOLD:    pc_next = PC;
                INC:     pc_next = inc;
                BRANCH:  pc_next = rel_target;
                JREL:    pc_next = PC + PC_W'(A);
                JABS:    pc_next = PC_W'(A);
                CALL: begin
                    if (stack_full) begin
                        set_ovf = 1'b1;
                    end else begin
                        push    = 1'b1;
                        pc_next = rel_target;
                    end
                end
                RET: begin
                    if (stack_empty) begin
                        set_unf = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        pc_next = top;
                    end
                end
                default: set_ill = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            PC      <= PC_W'(RESET_PC);
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
            err_ill <= 1'b0;
        end else begin
            PC <= pc_next;
            if (set_ovf) err_ovf <= 1'b1;
            if (set_unf) err_unf <= 1'b1;
            if (set_ill) err_ill <= 1'b1;
        end
    end

    pc_return_stack #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH),
        .SP_W  (SP_W)
    ) u_stack (
        .clk   (clk_main),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .din   (inc),
        .top   (top),
        .sp    (sp),
        .full  (stack_full),
        .empty (stack_empty)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized checks of pc_sequencer against a queue-based model
module tb_pc_sequencer;

    localparam int PC_W  = 6;
    localparam int A_W   = 4;
    localparam int OFF_W = 4;
    localparam int DEPTH = 4;
    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int MOD   = 1 << PC_W;

    logic             clk_main = 1'b0;
    logic             reset;
    logic             stall;
    logic [2:0]       ps;
    logic [A_W-1:0]   a;
    logic [OFF_W-1:0] offset;
    logic [PC_W-1:0]  pc;
    logic [SP_W-1:0]  sp;
    logic             stack_full;
    logic             stack_empty;
    logic             err_ovf;
    logic             err_unf;
    logic             err_ill;

    int total = 0;
    int bad   = 0;

    int m_pc;
    int m_stack[$];
    bit m_ovf;
    bit m_unf;
    bit m_ill;

    pc_sequencer #(
        .PC_W     (PC_W),
        .A_W      (A_W),
        .OFF_W    (OFF_W),
        .DEPTH    (DEPTH),
        .RESET_PC (0)
    ) dut (
        .clk_main    (clk_main),
        .reset       (reset),
        .stall       (stall),
        .PS          (ps),
        .A           (a),
        .offset      (offset),
        .PC          (pc),
        .sp          (sp),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .err_ovf     (err_ovf),
        .err_unf     (err_unf),
        .err_ill     (err_ill)
    );

    always #5 clk_main = ~clk_main;

    function automatic int wrap(input int v);
        return ((v % MOD) + MOD) % MOD;
    endfunction

    task automatic model_reset();
        m_pc = 0;
        m_stack.delete();
        m_ovf = 0;
        m_unf = 0;
        m_ill = 0;
    endtask

    task automatic model_step(input logic st, input logic [2:0] p, input logic [3:0] av, input logic [3:0] ov);
        int offs;
        offs = ov[3] ? int'(ov) - 16 : int'(ov);
        if (st) return;
        case (p)
            3'd0: ;
            3'd1: m_pc = wrap(m_pc + 1);
            3'd2: m_pc = wrap(m_pc + offs + 1);
            3'd3: m_pc = wrap(m_pc + int'(av));
            3'd4: m_pc = int'(av);
            3'd5: begin
                if (m_stack.size() == DEPTH) m_ovf = 1;
                else begin
                    m_stack.push_back(wrap(m_pc + 1));
                    m_pc = wrap(m_pc + offs + 1);
                end
            end
            3'd6: begin
                if (m_stack.size() == 0) m_unf = 1;
                else m_pc = m_stack.pop_back();
            end
            default: m_ill = 1;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".pc"},    32'(pc),          32'(m_pc));
        chk({tag, ".sp"},    32'(sp),          32'(m_stack.size()));
        chk({tag, ".full"},  32'(stack_full),  32'(m_stack.size() == DEPTH));
        chk({tag, ".empty"}, 32'(stack_empty), 32'(m_stack.size() == 0));
        chk({tag, ".ovf"},   32'(err_ovf),     32'(m_ovf));
        chk({tag, ".unf"},   32'(err_unf),     32'(m_unf));
        chk({tag, ".ill"},   32'(err_ill),     32'(m_ill));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic op(input logic st, input logic [2:0] p, input logic [3:0] av, input logic [3:0] ov, input string tag);
        stall  = st;
        ps     = p;
        a      = av;
        offset = ov;
        @(posedge clk_main);
        model_step(st, p, av, ov);
        #1;
        check_state(tag);
        @(negedge clk_main);
    endtask

    // Asynchronous reset asserted mid-cycle and checked before any clock edge.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_state(tag);
        chk({tag, ".pc0"}, 32'(pc), 32'd0);
        @(negedge clk_main);
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        stall  = 1'b0;
        ps     = 3'd0;
        a      = '0;
        offset = '0;
        #1;
        model_reset();
        check_state("por");
        @(negedge clk_main);
        reset = 1'b0;

        // reset and increment
        repeat (3) op(1'b0, 3'd1, 4'd0, 4'd0, "inc");
        chk("inc3", 32'(pc), 32'd3);
        do_reset("rst_mid");

        // branches and wrap
        op(1'b0, 3'd4, 4'd10, 4'd0, "jabs10");
        op(1'b0, 3'd2, 4'd0, 4'b1110, "br_neg");
        chk("br_neg_lit", 32'(pc), 32'd9);
        do_reset("rst_a");
        repeat (2) op(1'b0, 3'd2, 4'd0, 4'b1110, "br_back");
        chk("pc62", 32'(pc), 32'd62);
        op(1'b0, 3'd2, 4'd0, 4'b0011, "br_wrap");
        chk("br_wrap_lit", 32'(pc), 32'd2);
        do_reset("rst_b");
        repeat (4) op(1'b0, 3'd2, 4'd0, 4'b1110, "br_back");
        chk("pc60", 32'(pc), 32'd60);
        op(1'b0, 3'd3, 4'd5, 4'd0, "jrel_wrap");
        chk("jrel_wrap_lit", 32'(pc), 32'd1);
        op(1'b0, 3'd4, 4'd9, 4'd0, "jabs9");
        chk("jabs9_lit", 32'(pc), 32'd9);

        // call/return nesting
        op(1'b0, 3'd4, 4'd5, 4'd0, "jabs5");
        op(1'b0, 3'd5, 4'd0, 4'd2, "call1"); chk("call1_lit", 32'(pc), 32'd8);
        op(1'b0, 3'd5, 4'd0, 4'd2, "call2"); chk("call2_lit", 32'(pc), 32'd11);
        op(1'b0, 3'd5, 4'd0, 4'd2, "call3"); chk("call3_lit", 32'(pc), 32'd14);
        op(1'b0, 3'd5, 4'd0, 4'd2, "call4"); chk("call4_lit", 32'(pc), 32'd17);
        chk("sp4", 32'(sp), 32'd4);
        chk("full4", 32'(stack_full), 32'd1);
        op(1'b0, 3'd6, 4'd0, 4'd0, "ret1"); chk("ret1_lit", 32'(pc), 32'd15);
        op(1'b0, 3'd6, 4'd0, 4'd0, "ret2"); chk("ret2_lit", 32'(pc), 32'd12);
        op(1'b0, 3'd6, 4'd0, 4'd0, "ret3"); chk("ret3_lit", 32'(pc), 32'd9);
        op(1'b0, 3'd6, 4'd0, 4'd0, "ret4"); chk("ret4_lit", 32'(pc), 32'd6);
        chk("sp0", 32'(sp), 32'd0);
        chk("no_err", 32'({err_ovf, err_unf, err_ill}), 32'd0);

        // back-to-back call then return
        op(1'b0, 3'd5, 4'd0, 4'd7, "b2b_call");
        op(1'b0, 3'd6, 4'd0, 4'd0, "b2b_ret");
        chk("b2b_lit", 32'(pc), 32'd7);

        // overflow and underflow
        repeat (4) op(1'b0, 3'd5, 4'd0, 4'd1, "fill");
        op(1'b0, 3'd5, 4'd0, 4'd1, "ovf");
        chk("ovf_lit", 32'(err_ovf), 32'd1);
        chk("ovf_sp", 32'(sp), 32'd4);
        repeat (2) op(1'b0, 3'd1, 4'd0, 4'd0, "ovf_sticky");
        chk("ovf_sticky_lit", 32'(err_ovf), 32'd1);
        do_reset("rst_c");
        op(1'b0, 3'd6, 4'd0, 4'd0, "unf");
        chk("unf_pc", 32'(pc), 32'd0);
        chk("unf_lit", 32'(err_unf), 32'd1);

        // stall and illegal select
        do_reset("rst_d");
        op(1'b0, 3'd4, 4'd3, 4'd0, "pre_stall");
        repeat (3) op(1'b1, 3'd5, 4'd0, 4'd2, "stall_call");
        chk("stall_pc", 32'(pc), 32'd3);
        chk("stall_sp", 32'(sp), 32'd0);
        op(1'b0, 3'd7, 4'd0, 4'd0, "ill");
        chk("ill_lit", 32'(err_ill), 32'd1);
        chk("ill_pc", 32'(pc), 32'd3);
        op(1'b1, 3'd6, 4'd0, 4'd0, "stall_ret");
        chk("stall_unf", 32'(err_unf), 32'd0);

        // randomized ops with occasional mid-cycle resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 40) == 0) begin
                do_reset("rnd_rst");
            end else begin
                op(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program sequencer: successor to the 6-bit program counter, with configurable PC width, a signed branch offset, an absolute jump, and a hardware call/return stack. It sits between the control unit, which drives the 3-bit select `PS`, and the instruction memory address port. It adds a pipeline stall and sticky fault flags for stack misuse and illegal selects.

## Interface
Parameters:
- `PC_W`, default 6: PC / address width.
- `A_W`, default 4: register operand width. `A_W <= PC_W`.
- `OFF_W`, default 4: branch offset width, two's complement. `OFF_W <= PC_W`.
- `DEPTH`, default 4: return-stack entries, `>= 2`.
- `RESET_PC`, default 0: PC value loaded at reset.

Ports:
- `clk_main`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `stall`, in, 1: freezes all state when high.
- `PS`, in, 3: operation select.
- `A`, in, `A_W`: register operand, unsigned.
- `offset`, in, `OFF_W`: signed branch offset.
- `PC`, out, `PC_W`: current program counter, registered.
- `sp`, out, `$clog2(DEPTH+1)`: number of valid stack entries.
- `stack_full`, out, 1: `sp == DEPTH`.
- `stack_empty`, out, 1: `sp == 0`.
- `err_ovf`, out, 1: sticky; set by a call while full.
- `err_unf`, out, 1: sticky; set by a return while empty.
- `err_ill`, out, 1: sticky; set by `PS = 111`.

## Operation
PS encodings, with `inc = PC + 1` and `off_sx = sign-extend(offset)`:
- 000 HOLD: `PC <= PC`.
- 001 INC: `PC <= inc`.
- 010 BRANCH: `PC <= PC + off_sx + 1`.
- 011 JREL: `PC <= PC + zero-extend(A)`.
- 100 JABS: `PC <= zero-extend(A)`.
- 101 CALL: push `inc`, then `PC <= PC + off_sx + 1`, `sp <= sp + 1`.
- 110 RET: `PC <= top of stack`, `sp <= sp - 1`.
- 111 ILLEGAL: `PC` holds; set `err_ill`.

Arithmetic and edge cases:
- All PC arithmetic is modulo 2^`PC_W`; wrap-around is silent. For example, with `PC_W = 6`, PC 63 followed by INC gives 0.
- CALL while `stack_full`: no push, PC holds, `sp` unchanged, set `err_ovf`.
- RET while `stack_empty`: PC holds, `sp` unchanged, set `err_unf`.
- `stall = 1` overrides `PS`: PC, stack, `sp` and all error flags hold. A faulting `PS` under stall does not set any flag.
- Error flags are cleared only by `reset`.
- `stack_full` and `stack_empty` are combinational decodes of the registered `sp`.
- Stack contents are not reset. Only `sp` defines validity.

## Timing
- Every operation completes in one cycle. The new `PC`, `sp` and flags are visible after the next `clk_main` rising edge.
- There is no multi-cycle state and no handshake beyond `stall`.
- Reset (asynchronous, immediate, mid-operation allowed) drives `PC = RESET_PC`, `sp = 0`, `stack_empty = 1`, `stack_full = 0`, and clears all `err_*`.
- Deasserting reset: the first edge with reset low executes `PS` normally.
- Back-to-back CALL/RET is allowed: a RET on the cycle after a CALL returns the value pushed by that CALL.
- The stack write on CALL and the `sp` update occur on the same edge as the PC update.

## Structure
- Package `pc_seq_pkg` holds:
  - the `ps_e` enum: HOLD, INC, BRANCH, JREL, JABS, CALL, RET, ILLEGAL (3-bit);
  - a `sext` helper function for offset sign-extension.
- Sub-module `pc_return_stack`, a parametrised `DEPTH` x `PC_W` LIFO:
  - inputs: `push`, `pop`, `din`;
  - outputs: `top`, `sp`, `full`, `empty`;
  - internally guards push-when-full and pop-when-empty (no state change).
- The top level contains:
  - the PC register;
  - next-PC mux;
  - fault detection;
  - the sticky error registers.

## Test plan
All scenarios use `PC_W = 6`, `OFF_W = 4`, `DEPTH = 4`, `RESET_PC = 0`.

1. Reset and increment: reset, then INC x3 → PC = 3. Assert reset asynchronously mid-cycle → PC = 0, `sp = 0`, `stack_empty = 1`, flags = 0 immediately.
2. Branches and wrap:
   - PC = 10, BRANCH with offset 4'b1110 (-2) → PC = 9.
   - PC = 62, BRANCH with offset 4'b0011 → PC = 2.
   - PC = 60, JREL with A = 5 → PC = 1.
   - JABS with A = 9 → PC = 9.
3. Call/return nesting: from PC = 5, four CALLs each with offset 2 → PCs 8, 11, 14, 17, `sp = 4`, `stack_full = 1`. Four RETs → PCs 15, 12, 9, 6, `sp = 0`, no errors.
4. Overflow and underflow:
   - With `sp = 4`, CALL → PC unchanged, `sp = 4`, `err_ovf = 1`, and it stays 1 through later INCs.
   - After reset, RET → PC = 0, `err_unf = 1`.
5. Stall and illegal select:
   - `stall = 1` with PS = CALL for 3 cycles → PC, `sp` and flags unchanged.
   - `stall = 0`, PS = 111 → PC holds, `err_ill = 1`.
   - `stall = 1` with PS = RET on an empty stack → `err_unf` stays 0.
